// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_div_unit_pkg -- shared ALU control, mul/div op and FSM state encodings
// Revision: 1.0
// ---------------------------------------------------------------------------
package mul_div_unit_pkg;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5;
   localparam logic [3:0] ALU_SLL = 4'd6;
   localparam logic [3:0] ALU_SRL = 4'd7;

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   function automatic logic op_is_div(input md_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input md_op_e op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_div_if -- request/result bundle between pipeline and mul_div_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
interface mul_div_if #(
   parameter int DATA_W = 32
);
   logic              enable;
   logic              start;
   logic [1:0]        op;
   logic [DATA_W-1:0] operand_a;
   logic [DATA_W-1:0] operand_b;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic              div_by_zero;

   modport master (
      output enable, start, op, operand_a, operand_b,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  enable, start, op, operand_a, operand_b,
      output busy, done, hi, lo, div_by_zero
   );
endinterface
`default_nettype wire

// File: rtl/mul_div_negate.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_div_negate -- conditional two's-complement of a WIDTH-bit value
// Revision: 1.0
// ---------------------------------------------------------------------------
module mul_div_negate #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] result
);
   assign result = neg ? (~value + WIDTH'(1)) : value;
endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_div_unit -- iterative radix-2 multiply / restoring divide, signed+unsigned
// Revision: 1.0
// ---------------------------------------------------------------------------
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic      clk,
   input  logic      arst_n,
   mul_div_if.slave  bus
);

   md_state_e         state;
   md_op_e            op_q;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] work_hi;
   logic [DATA_W-1:0] work_lo;
   logic [DATA_W-1:0] opnd;
   logic              sign_q;
   logic              sign_r;
   logic              zero_q;
   logic              busy_q;
   logic              done_q;
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic              dbz_q;

   md_op_e            req_op;
   logic              a_neg;
   logic              b_neg;
   logic [DATA_W-1:0] mag_a;
   logic [DATA_W-1:0] mag_b;
   logic [DATA_W:0]   mul_sum;
   logic [DATA_W:0]   div_shift;
   logic              div_ge;
   logic [DATA_W-1:0] div_diff;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0] quo_fix;
   logic [DATA_W-1:0] rem_fix;

   assign req_op = md_op_e'(bus.op);
   assign a_neg  = op_is_signed(req_op) & bus.operand_a[DATA_W-1];
   assign b_neg  = op_is_signed(req_op) & bus.operand_b[DATA_W-1];

   mul_div_negate #(.WIDTH(DATA_W)) u_mag_a (.neg(a_neg), .value(bus.operand_a), .result(mag_a));
   mul_div_negate #(.WIDTH(DATA_W)) u_mag_b (.neg(b_neg), .value(bus.operand_b), .result(mag_b));

   // Multiply: multiplier sits in work_lo and shifts out LSB-first as the product shifts in.
   assign mul_sum = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});

   // Divide: remainder in work_hi, dividend/quotient in work_lo; the difference fits DATA_W bits whenever it is kept.
   assign div_shift = {work_hi, work_lo[DATA_W-1]};
   assign div_ge    = (div_shift >= {1'b0, opnd});
   assign div_diff  = div_shift[DATA_W-1:0] - opnd;

   mul_div_negate #(.WIDTH(2*DATA_W)) u_fix_prod (.neg(sign_q), .value({work_hi, work_lo}), .result(prod_fix));
   mul_div_negate #(.WIDTH(DATA_W))   u_fix_quo  (.neg(sign_q), .value(work_lo), .result(quo_fix));
   mul_div_negate #(.WIDTH(DATA_W))   u_fix_rem  (.neg(sign_r), .value(work_hi), .result(rem_fix));

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state   <= ST_IDLE;
         op_q    <= OP_MULT;
         cnt     <= '0;
         work_hi <= '0;
         work_lo <= '0;
         opnd    <= '0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dbz_q   <= 1'b0;
      end else if (bus.enable) begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state   <= ST_CALC;
                  busy_q  <= 1'b1;
                  cnt     <= '0;
                  op_q    <= req_op;
                  work_hi <= '0;
                  work_lo <= op_is_div(req_op) ? mag_a : mag_b;
                  opnd    <= op_is_div(req_op) ? mag_b : mag_a;
                  sign_q  <= a_neg ^ b_neg;
                  sign_r  <= a_neg;
                  zero_q  <= (bus.operand_b == '0);
               end
            end
            ST_CALC: begin
               cnt <= cnt + CNT_W'(1);
               if (op_is_div(op_q)) begin
                  work_hi <= div_ge ? div_diff : div_shift[DATA_W-1:0];
                  work_lo <= {work_lo[DATA_W-2:0], div_ge};
               end else begin
                  work_hi <= mul_sum[DATA_W:1];
                  work_lo <= {mul_sum[0], work_lo[DATA_W-1:1]};
               end
               if (cnt == CNT_W'(DATA_W - 1)) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               if (op_is_div(op_q)) begin
                  // A zero divisor leaves the dividend magnitude in the remainder; only the quotient is forced.
                  hi_q  <= rem_fix;
                  lo_q  <= zero_q ? {DATA_W{1'b1}} : quo_fix;
                  dbz_q <= zero_q;
               end else begin
                  hi_q  <= prod_fix[2*DATA_W-1:DATA_W];
                  lo_q  <= prod_fix[DATA_W-1:0];
                  dbz_q <= 1'b0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_div_unit -- directed vectors with hand-computed results for mul_div_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

   localparam logic [1:0] MULT  = 2'd0;
   localparam logic [1:0] MULTU = 2'd1;
   localparam logic [1:0] DIV   = 2'd2;
   localparam logic [1:0] DIVU  = 2'd3;

   logic clk;
   logic arst_n;
   int   total;
   int   bad;

   mul_div_if #(.DATA_W(32)) bus ();

   mul_div_unit #(.DATA_W(32)) dut (
      .clk    (clk),
      .arst_n (arst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; consumes the edge that samples start.
   task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.op        = op;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.start     = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int lat0, output int lat, output int bcnt);
      lat  = lat0;
      bcnt = bus.busy ? 1 : 0;
      while (!bus.done && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.busy) bcnt++;
      end
   endtask

   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic ez);
      int lat;
      int bcnt;
      do_start(op, a, b);
      wait_done(0, lat, bcnt);
      check({tag, ".lat"}, 64'(lat), 64'd33);
      check({tag, ".hi"}, {32'd0, bus.hi}, {32'd0, eh});
      check({tag, ".lo"}, {32'd0, bus.lo}, {32'd0, el});
      check({tag, ".dbz"}, {63'd0, bus.div_by_zero}, {63'd0, ez});
      check({tag, ".busy_at_done"}, {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      int lat;
      int bcnt;
      int dcnt;
      total         = 0;
      bad           = 0;
      arst_n        = 1'b0;
      bus.enable    = 1'b1;
      bus.start     = 1'b0;
      bus.op        = MULT;
      bus.operand_a = '0;
      bus.operand_b = '0;

      #3;
      check("reset.busy", {63'd0, bus.busy}, 64'd0);
      check("reset.done", {63'd0, bus.done}, 64'd0);
      check("reset.hilo", {bus.hi, bus.lo}, 64'd0);
      check("reset.dbz", {63'd0, bus.div_by_zero}, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 arst_n = 1'b1;

      // Signed multiply with latency and busy-length check
      do_start(MULT, 32'hFFFF_FFFD, 32'd7);
      wait_done(0, lat, bcnt);
      check("mult_neg.lat", 64'(lat), 64'd33);
      check("mult_neg.busy_cycles", 64'(bcnt), 64'd33);
      check("mult_neg.hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      @(posedge clk);
      #1;
      check("mult_neg.done_pulse", {63'd0, bus.done}, 64'd0);

      do_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      do_op("mult_min",  MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
      do_op("div_neg",   DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      do_op("div_negb",  DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      do_op("divu_zero", DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1);
      do_op("multu_clr", MULTU, 32'd6,         32'd7,         32'd0,         32'd42,        1'b0);
      do_op("div_zero",  DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
      do_op("div_min",   DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

      // start held high through busy, then accepted on the done cycle
      do_start(DIVU, 32'd100, 32'd7);
      bus.op        = MULTU;
      bus.operand_a = 32'd3;
      bus.operand_b = 32'd5;
      bus.start     = 1'b1;
      wait_done(0, lat, bcnt);
      check("b2b.first_lat", 64'(lat), 64'd33);
      check("b2b.first", {bus.hi, bus.lo}, {32'd2, 32'd14});
      do_start(MULTU, 32'd3, 32'd5);
      check("b2b.accept_busy", {63'd0, bus.busy}, 64'd1);
      wait_done(1, lat, bcnt);
      check("b2b.second_gap", 64'(lat), 64'd34);
      check("b2b.second", {bus.hi, bus.lo}, {32'd0, 32'd15});

      // enable dropped for 5 cycles mid-CALC
      do_start(MULTU, 32'd2, 32'd3);
      lat = 0;
      repeat (9) begin
         @(posedge clk);
         #1 lat++;
      end
      bus.enable = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1 lat++;
      end
      check("stall.busy", {63'd0, bus.busy}, 64'd1);
      check("stall.hold", {bus.hi, bus.lo}, {32'd0, 32'd15});
      bus.enable = 1'b1;
      wait_done(lat, lat, bcnt);
      check("stall.lat", 64'(lat), 64'd38);
      check("stall.hilo", {bus.hi, bus.lo}, {32'd0, 32'd6});

      // asynchronous reset in the middle of a divide
      do_start(DIV, 32'hFFFF_FF9C, 32'd7);
      repeat (9) @(posedge clk);
      #2 arst_n = 1'b0;
      #1;
      check("arst.busy", {63'd0, bus.busy}, 64'd0);
      check("arst.hilo", {bus.hi, bus.lo}, 64'd0);
      dcnt = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus.done) dcnt++;
      end
      arst_n = 1'b1;
      check("arst.no_done", 64'(dcnt), 64'd0);
      do_op("after_rst", DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width in bits; legal values are even and 8..64.
REQ-002 Parameter CNT_W, default $clog2(DATA_W)+1, iteration counter width; it is derived and is not overridden.
REQ-003 clk  input  1  main clock; all state is updated on the rising edge.
REQ-004 arst_n  input  1  reset, asynchronous and active-low.
REQ-005 enable  input  1  global run enable; while low, all state and outputs hold.
REQ-006 start  input  1  request a new operation; sampled only in IDLE with enable high.
REQ-007 op  input  2  operation select: 0 MULT (signed), 1 MULTU, 2 DIV (signed), 3 DIVU.
REQ-008 operand_a  input  DATA_W  multiplicand or dividend (rs).
REQ-009 operand_b  input  DATA_W  multiplier or divisor (rt).
REQ-010 busy  output  1  an operation is in flight; the pipeline stalls on it.
REQ-011 done  output  1  single-cycle pulse: hi and lo are updated and valid.
REQ-012 hi  output  DATA_W  product upper half, or remainder.
REQ-013 lo  output  DATA_W  product lower half, or quotient.
REQ-014 div_by_zero  output  1  sticky per operation: the last division had operand_b == 0.

Function
REQ-015 The FSM states shall be IDLE, CALC and FIX; all state shall be registered.
REQ-016 IDLE to CALC: on a clock edge with enable=1 and start=1, capture op, the operand magnitudes (absolute values for signed ops) and the result-sign bits, and clear the iteration counter.
REQ-017 CALC: perform one radix-2 iteration per enabled edge (shift-add for multiply, restoring shift-subtract for divide) for exactly DATA_W iterations, then go to FIX.
REQ-018 FIX: apply sign correction on one enabled edge, write hi and lo, assert done for the following cycle only, and return to IDLE.
REQ-019 Latency: if start is sampled at edge k, hi, lo and done become visible after edge k+DATA_W+1, assuming enable stays high throughout.
REQ-020 busy=1 exactly while the state is CALC or FIX; busy=0 in IDLE, including the cycle in which done=1.
REQ-021 Multiply: {hi,lo} = the full 2*DATA_W-bit product; signed ops use two's-complement semantics.
REQ-022 Signed divide: the quotient truncates toward zero; the remainder takes the sign of the dividend.
REQ-023 Divide by zero: lo = all ones, hi = operand_a, div_by_zero=1, with normal latency.
REQ-024 Signed divide of MIN by -1: lo = MIN, hi = 0, no flag.
REQ-025 div_by_zero shall be updated at FIX of every division, cleared at FIX of every multiplication, and held otherwise.
REQ-026 start while busy=1 shall be ignored and not queued; the caller must hold off until busy=0.
REQ-027 start in the same cycle as done (state IDLE) shall be accepted; back-to-back operations therefore have a throughput of one per DATA_W+2 cycles.
REQ-028 enable=0 at any point shall freeze the state, counter and datapath, and suspend the done pulse until enable returns.
REQ-029 hi and lo shall hold their last results in IDLE and while busy; they change only at FIX.

Reset
REQ-030 Assertion of arst_n=0 shall, immediately and asynchronously, set: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, div_by_zero 0, and all internal datapath registers 0.
REQ-031 Reset during CALC or FIX shall abandon the operation; no done pulse follows.
REQ-032 The first start shall be accepted on the first enabled edge after arst_n rises.

Structure
REQ-033 The op encodings (MULT/MULTU/DIV/DIVU) and FSM state encodings shall live in a shared package, alongside the existing ALU control constants.
REQ-034 One sub-module, mul_div_negate (parametrised conditional two's-complement), shall be instantiated for operand magnitude and result sign-fix.
REQ-035 No memories shall be used; registers shall use the team's async-reset enable-register style.

Verification (DATA_W=32)
REQ-036 MULT a=0xFFFFFFFD (-3), b=7 -> done after 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
REQ-037 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, div_by_zero=1.
REQ-039 DIVU 100/7, then start held during busy, then start on the done cycle with MULTU 3*5 -> first result lo=14, hi=2; the mid-op start is ignored; second result lo=15 exactly 34 cycles after the first done.
REQ-040 MULTU 2*3 with enable dropped for 5 cycles mid-CALC -> done 38 cycles after start; result lo=6.
REQ-041 arst_n pulsed low at iteration 10 of a DIV -> outputs are 0 immediately and no done occurs; a fresh op after release completes normally.
